// File: rtl/ramb_arbiter_if.sv
// ramb_arbiter_if: bundle of every port-B signal around the arbiter.
//   VGA side : v_req, v_addr -> v_gnt, v_rdata, v_rvalid
//   Host side: h_req, h_we, h_addr, h_wdata -> h_gnt, h_rdata, h_rvalid
//   RAM side : ram_addr_b, ram_data_b, ram_wren_b -> RAM ; ram_q_b <- RAM
//   Stats    : h_forced
// Modport slave is the arbiter. Modport master is everything around it
// (requesters and the RAM).
//
// Handshake: a transfer happens in any cycle where req && gnt. A requester
// holds req/addr/we/wdata stable until it sees gnt. gnt is combinational
// from req, so a requester may issue a new request in the cycle straight
// after its grant. Read data comes back as a one-cycle rvalid pulse with
// rdata, strictly in grant order.
interface ramb_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          v_req;
  logic [AW-1:0] v_addr;
  logic          v_gnt;
  logic [DW-1:0] v_rdata;
  logic          v_rvalid;

  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt;
  logic [DW-1:0] h_rdata;
  logic          h_rvalid;

  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_data_b;
  logic          ram_wren_b;
  logic [DW-1:0] ram_q_b;

  logic          h_forced;

  modport slave (
    input  v_req, v_addr, h_req, h_we, h_addr, h_wdata, ram_q_b,
    output v_gnt, v_rdata, v_rvalid, h_gnt, h_rdata, h_rvalid,
    output ram_addr_b, ram_data_b, ram_wren_b, h_forced
  );

  modport master (
    output v_req, v_addr, h_req, h_we, h_addr, h_wdata, ram_q_b,
    input  v_gnt, v_rdata, v_rvalid, h_gnt, h_rdata, h_rvalid,
    input  ram_addr_b, ram_data_b, ram_wren_b, h_forced
  );
endinterface

// File: rtl/ramb_arbiter.sv
// ramb_arbiter: shares RAM port B between the VGA pixel fetcher (fixed
// priority, read-only) and the host/loader port (read/write). One access
// per cycle, RAM command pins registered, read data routed back to the
// issuer via a tag pipeline of depth RD_LAT.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - ramb_arbiter_if.slave (requesters, RAM port B, h_forced)
// Parameters: AW/DW address/data width, RD_LAT grant-to-q_b latency (1..4),
// MAX_WAIT host wait cycles before a forced grant (1..255).
module ramb_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  ramb_arbiter_if.slave   bus
);

  logic [7:0]        h_wait;
  logic              v_gnt;
  logic              h_gnt;
  logic              force_h;
  logic              rd_push;

  logic [AW-1:0]     ram_addr_q;
  logic [DW-1:0]     ram_data_q;
  logic              ram_wren_q;
  logic              h_forced_q;

  // tag_v[i]: a read is in flight at stage i; tag_o[i]: its owner (1 = host)
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_o;

  logic [DW-1:0]     v_rdata_q;
  logic [DW-1:0]     h_rdata_q;
  logic              v_rvalid_q;
  logic              h_rvalid_q;

  // Grant decision. The forced host grant outranks VGA; otherwise VGA wins.
  always_comb begin
    v_gnt   = 1'b0;
    h_gnt   = 1'b0;
    force_h = 1'b0;
    if (!reset) begin
      if (bus.h_req && (h_wait == 8'(MAX_WAIT))) begin
        h_gnt   = 1'b1;
        force_h = 1'b1;
      end else if (bus.v_req) begin
        v_gnt = 1'b1;
      end else if (bus.h_req) begin
        h_gnt = 1'b1;
      end
    end
  end

  assign rd_push = v_gnt || (h_gnt && !bus.h_we);

  // Host wait counter: counts cycles the host has been kept waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_wait <= 8'd0;
    end else if (!bus.h_req || h_gnt) begin
      h_wait <= 8'd0;
    end else if (h_wait != 8'(MAX_WAIT)) begin
      h_wait <= h_wait + 8'd1;
    end
  end

  // RAM command register. Address/data hold when idle so the RAM sees
  // stable pins; only wren drops back to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
      h_forced_q <= 1'b0;
    end else begin
      ram_wren_q <= h_gnt && bus.h_we;
      h_forced_q <= force_h;
      if (v_gnt) begin
        ram_addr_q <= bus.v_addr;
      end else if (h_gnt) begin
        ram_addr_q <= bus.h_addr;
      end
      if (h_gnt && bus.h_we) begin
        ram_data_q <= bus.h_wdata;
      end
    end
  end

  // Tag pipeline. Stage RD_LAT-1 is visible in the cycle where ram_q_b holds
  // the word for that read, so the return registers capture it there.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v[0] <= rd_push;
      tag_o[0] <= h_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_o[i] <= tag_o[i-1];
      end
    end
  end

  // Read return: only the owner's rdata updates; the other side holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_rdata_q  <= '0;
      h_rdata_q  <= '0;
      v_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
    end else begin
      v_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      if (tag_v[RD_LAT-1]) begin
        if (tag_o[RD_LAT-1]) begin
          h_rdata_q  <= bus.ram_q_b;
          h_rvalid_q <= 1'b1;
        end else begin
          v_rdata_q  <= bus.ram_q_b;
          v_rvalid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.v_gnt      = v_gnt;
  assign bus.h_gnt      = h_gnt;
  assign bus.ram_addr_b = ram_addr_q;
  assign bus.ram_data_b = ram_data_q;
  assign bus.ram_wren_b = ram_wren_q;
  assign bus.h_forced   = h_forced_q;
  assign bus.v_rdata    = v_rdata_q;
  assign bus.h_rdata    = h_rdata_q;
  assign bus.v_rvalid   = v_rvalid_q;
  assign bus.h_rvalid   = h_rvalid_q;

endmodule

// File: tb/tb_ramb_arbiter.sv
// tb_ramb_arbiter: directed bench for ramb_arbiter. Two instances: u_dut
// with default parameters, u_dut1 with MAX_WAIT = 1 for VGA/host
// interleaving. Each has a small RAM model (1 cycle from pins to q_b, so
// q_b is valid RD_LAT = 2 cycles after grant) and a read-return monitor
// that pops expected {owner, data} and arrival cycle from queues filled by
// the stimulus at grant time.
module tb_ramb_arbiter;
  localparam int AW     = 8;
  localparam int DW     = 8;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  ramb_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();
  ramb_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

  ramb_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(15)) u_dut (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  ramb_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM models (preloaded during reset) ----------------
  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem1 [256];

  always @(posedge clk) begin
    if (reset) begin
      mem0[8'h10] <= 8'hA5;
      mem0[8'h11] <= 8'h5A;
      mem0[8'h30] <= 8'h77;
    end else if (bus0.ram_wren_b) begin
      mem0[bus0.ram_addr_b] <= bus0.ram_data_b;
    end
    bus0.ram_q_b <= mem0[bus0.ram_addr_b];
  end

  always @(posedge clk) begin
    if (reset) begin
      mem1[8'h01] <= 8'h11;
      mem1[8'h02] <= 8'h22;
    end else if (bus1.ram_wren_b) begin
      mem1[bus1.ram_addr_b] <= bus1.ram_data_b;
    end
    bus1.ram_q_b <= mem1[bus1.ram_addr_b];
  end

  // ---------------- scoreboard ----------------
  logic [DW:0] exp0_q[$];
  logic [DW:0] exp1_q[$];
  int          cyc0_q[$];
  int          cyc1_q[$];
  logic [DW:0] e0, e1;
  int          c0, c1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus0.v_rvalid || bus0.h_rvalid) begin
      if (exp0_q.size() == 0) begin
        check("rv0_spurious", 64'({bus0.h_rvalid, bus0.v_rvalid}), 64'd0);
      end else begin
        e0 = exp0_q.pop_front();
        c0 = cyc0_q.pop_front();
        check("rv0_owner", 64'({bus0.h_rvalid, bus0.v_rvalid}), e0[DW] ? 64'd2 : 64'd1);
        check("rv0_data", 64'(e0[DW] ? bus0.h_rdata : bus0.v_rdata), 64'(e0[DW-1:0]));
        check("rv0_cycle", 64'(cyc), 64'(c0));
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.v_rvalid || bus1.h_rvalid) begin
      if (exp1_q.size() == 0) begin
        check("rv1_spurious", 64'({bus1.h_rvalid, bus1.v_rvalid}), 64'd0);
      end else begin
        e1 = exp1_q.pop_front();
        c1 = cyc1_q.pop_front();
        check("rv1_owner", 64'({bus1.h_rvalid, bus1.v_rvalid}), e1[DW] ? 64'd2 : 64'd1);
        check("rv1_data", 64'(e1[DW] ? bus1.h_rdata : bus1.v_rdata), 64'(e1[DW-1:0]));
        check("rv1_cycle", 64'(cyc), 64'(c1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [63:0] outs0();
    return 64'({bus0.ram_addr_b, bus0.ram_data_b, bus0.ram_wren_b, bus0.v_rdata,
                bus0.h_rdata, bus0.v_rvalid, bus0.h_rvalid, bus0.h_forced,
                bus0.v_gnt, bus0.h_gnt});
  endfunction

  task automatic push0(input logic owner, input logic [DW-1:0] d);
    exp0_q.push_back({owner, d});
    cyc0_q.push_back(cyc + RD_LAT + 1);
  endtask

  task automatic push1(input logic owner, input logic [DW-1:0] d);
    exp1_q.push_back({owner, d});
    cyc1_q.push_back(cyc + RD_LAT + 1);
  endtask

  task automatic v_op(input logic [AW-1:0] addr, input logic [DW-1:0] exp_d);
    @(posedge clk); #1;
    bus0.v_req  = 1'b1;
    bus0.v_addr = addr;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus0.v_gnt) break;
    end
    check("v_gnt", 64'(bus0.v_gnt), 64'd1);
    check("v_excl", 64'(bus0.h_gnt), 64'd0);
    push0(1'b0, exp_d);
    @(posedge clk); #1;
    bus0.v_req = 1'b0;
    @(negedge clk);
    check("v_cmd_addr", 64'(bus0.ram_addr_b), 64'(addr));
    check("v_cmd_wren", 64'(bus0.ram_wren_b), 64'd0);
  endtask

  task automatic h_op(input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [DW-1:0] exp_d);
    @(posedge clk); #1;
    bus0.h_req   = 1'b1;
    bus0.h_we    = we;
    bus0.h_addr  = addr;
    bus0.h_wdata = wdata;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus0.h_gnt) break;
    end
    check("h_gnt", 64'(bus0.h_gnt), 64'd1);
    check("h_excl", 64'(bus0.v_gnt), 64'd0);
    if (!we) push0(1'b1, exp_d);
    @(posedge clk); #1;
    bus0.h_req = 1'b0;
    @(negedge clk);
    check("h_cmd_addr", 64'(bus0.ram_addr_b), 64'(addr));
    check("h_cmd_wren", 64'(bus0.ram_wren_b), 64'(we));
    if (we) begin
      check("h_cmd_data", 64'(bus0.ram_data_b), 64'(wdata));
      @(negedge clk);
      check("h_wren_pulse", 64'(bus0.ram_wren_b), 64'd0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp0_q.size() == 0 && exp1_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain0", 64'(exp0_q.size()), 64'd0);
    check("drain1", 64'(exp1_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    bus0.v_req = 1'b0; bus0.v_addr = '0;
    bus0.h_req = 1'b0; bus0.h_we = 1'b0; bus0.h_addr = '0; bus0.h_wdata = '0;
    bus1.v_req = 1'b0; bus1.v_addr = '0;
    bus1.h_req = 1'b0; bus1.h_we = 1'b0; bus1.h_addr = '0; bus1.h_wdata = '0;

    // Requests during reset must not be granted
    @(posedge clk); #1;
    bus0.v_req = 1'b1;
    bus0.h_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs0(), 64'd0);
    @(posedge clk); #1;
    bus0.v_req = 1'b0;
    bus0.h_req = 1'b0;
    reset = 1'b0;

    // Idle: everything stays at zero
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", outs0(), 64'd0);
    end

    // VGA read of preloaded word
    v_op(8'h10, 8'hA5);

    // Host write then read back
    h_op(1'b1, 8'h20, 8'h3C, 8'h00);
    h_op(1'b0, 8'h20, 8'h00, 8'h3C);
    h_op(1'b0, 8'h10, 8'h00, 8'hA5);
    v_op(8'h11, 8'h5A);
    repeat (3) @(negedge clk);
    check("h_rdata_hold", 64'(bus0.h_rdata), 64'hA5);
    check("v_rdata_last", 64'(bus0.v_rdata), 64'h5A);

    // Back-to-back host read then write of the same address: read sees old data
    @(posedge clk); #1;
    bus0.h_req = 1'b1; bus0.h_we = 1'b0; bus0.h_addr = 8'h30;
    @(negedge clk);
    check("b2b_rd_gnt", 64'(bus0.h_gnt), 64'd1);
    push0(1'b1, 8'h77);
    @(posedge clk); #1;
    bus0.h_we = 1'b1; bus0.h_wdata = 8'h99;
    @(negedge clk);
    check("b2b_wr_gnt", 64'(bus0.h_gnt), 64'd1);
    check("b2b_rd_cmd", 64'({bus0.ram_wren_b, bus0.ram_addr_b}), 64'h030);
    @(posedge clk); #1;
    bus0.h_req = 1'b0;
    @(negedge clk);
    check("b2b_wr_cmd", 64'({bus0.ram_wren_b, bus0.ram_addr_b, bus0.ram_data_b}), 64'h13099);
    h_op(1'b0, 8'h30, 8'h00, 8'h99);

    // Starvation: VGA continuous, host forced at cycle 15
    drain();
    @(posedge clk); #1;
    bus0.v_req = 1'b1; bus0.v_addr = 8'h11;
    bus0.h_req = 1'b1; bus0.h_we = 1'b0; bus0.h_addr = 8'h10;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 15) begin
        check("starve_h_gnt", 64'(bus0.h_gnt), 64'd1);
        check("starve_v_low", 64'(bus0.v_gnt), 64'd0);
        check("starve_forced_pre", 64'(bus0.h_forced), 64'd0);
        push0(1'b1, 8'hA5);
      end else begin
        check("starve_v_gnt", 64'(bus0.v_gnt), 64'd1);
        check("starve_h_wait", 64'(bus0.h_gnt), 64'd0);
        if (k == 16) check("starve_forced", 64'(bus0.h_forced), 64'd1);
        push0(1'b0, 8'h5A);
      end
      @(posedge clk); #1;
      if (k == 15) bus0.h_req = 1'b0;
    end
    bus0.v_req = 1'b0;
    @(negedge clk);
    check("forced_pulse_end", 64'(bus0.h_forced), 64'd0);

    // Interleaved reads on the MAX_WAIT = 1 instance
    drain();
    @(posedge clk); #1;
    bus1.v_req = 1'b1; bus1.v_addr = 8'h01;
    bus1.h_req = 1'b1; bus1.h_we = 1'b0; bus1.h_addr = 8'h02;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("il_gnt", 64'({bus1.h_gnt, bus1.v_gnt}), (k % 2 == 1) ? 64'd2 : 64'd1);
      check("il_forced", 64'(bus1.h_forced), (k % 2 == 0 && k > 0) ? 64'd1 : 64'd0);
      if (k % 2 == 1) push1(1'b1, 8'h22);
      else            push1(1'b0, 8'h11);
      @(posedge clk); #1;
    end
    bus1.v_req = 1'b0;
    bus1.h_req = 1'b0;

    // Reset while a VGA read is in flight: no rvalid may ever appear
    drain();
    @(posedge clk); #1;
    bus0.v_req = 1'b1; bus0.v_addr = 8'h10;
    @(negedge clk);
    check("rst_flight_gnt", 64'(bus0.v_gnt), 64'd1);
    @(posedge clk); #1;
    bus0.v_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_flight_outputs", outs0(), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);

    drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ramb_arbiter.md
# ramb_arbiter

Arbiter for port B of the shared dual-port data RAM. The CPU keeps exclusive use of port A. Port B is shared between two requesters:
- the VGA pixel fetcher (read-only, latency-critical);
- a host/loader port (read/write, used for debug and framebuffer preload).

The block grants at most one port-B access per cycle, drives the RAM port-B pins from registers, and returns read data to the requester that issued the read. VGA has fixed priority; an anti-starvation counter bounds how long the host can wait.

## Interface
Parameters:
- AW, 8, RAM port-B address width
- DW, 8, RAM port-B data width
- RD_LAT, 2, cycles from grant until ram_q_b holds the addressed word; legal range 1–4
- MAX_WAIT, 15, host wait cycles before a forced host grant; legal range 1–255

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- v_req  in  1  VGA read request
- v_addr  in  AW  VGA read address
- v_gnt  out  1  VGA request accepted this cycle
- v_rdata  out  DW  VGA read data
- v_rvalid  out  1  v_rdata valid, one-cycle pulse
- h_req  in  1  host request
- h_we  in  1  host write (1) or read (0)
- h_addr  in  AW  host address
- h_wdata  in  DW  host write data
- h_gnt  out  1  host request accepted this cycle
- h_rdata  out  DW  host read data
- h_rvalid  out  1  h_rdata valid, one-cycle pulse
- ram_addr_b  out  AW  to RAM address_b, registered
- ram_data_b  out  DW  to RAM data_b, registered
- ram_wren_b  out  1  to RAM wren_b, registered
- ram_q_b  in  DW  from RAM q_b
- h_forced  out  1  registered; high in the cycle after a forced host grant (statistics)

## Operation
Handshake:
- A transfer occurs in a cycle where req && gnt are both high.
- The requester must hold req, addr, we and wdata stable until it is granted.
- gnt is combinational from the req inputs and the registered wait counter.
- v_gnt and h_gnt are never high in the same cycle.

Arbitration, evaluated each cycle:
- If h_wait == MAX_WAIT and h_req is high: h_gnt = 1. This is a forced grant and applies even when v_req is high.
- Else if v_req is high: v_gnt = 1.
- Else if h_req is high: h_gnt = 1.
- Else no grant.

Wait counter h_wait (8 bits):
- Cleared on reset.
- Cleared in any cycle where h_req is low or h_gnt is high.
- Otherwise incremented, saturating at MAX_WAIT.

RAM command register (updated at the edge ending a grant cycle):
- ram_addr_b takes the granted address.
- ram_data_b takes h_wdata on a host write; otherwise it holds its previous value.
- ram_wren_b = 1 only for a granted host write.
- With no grant: ram_wren_b = 0, and address/data hold their values.

Read-return tag pipeline:
- Depth RD_LAT. Each entry is {valid, owner}; owner is 0 for VGA, 1 for host.
- A granted read pushes {1, owner}. A granted write or no grant pushes {0, x}.
- When the tag reaching the end of the pipe is valid, ram_q_b is registered into the owner's rdata and the owner's rvalid is pulsed. The other requester's rdata holds its value and its rvalid stays 0.
- Writes never produce an rvalid.
- Reads return strictly in grant order.

Reset:
- All outputs are 0: ram_addr_b, ram_data_b, ram_wren_b, v_rdata, h_rdata, v_rvalid, h_rvalid, h_forced. h_wait = 0.
- The tag pipeline is cleared. A read in flight when reset asserts never produces rvalid.
- While reset is high, v_gnt and h_gnt are 0.

## Timing
- Grant in cycle t → RAM command visible on ram_* pins in cycle t+1.
- ram_q_b is valid in cycle t+RD_LAT.
- rvalid/rdata are high in cycle t+RD_LAT+1 (t+3 with defaults).
- Throughput: one access per cycle with back-to-back grants. A read at t followed by a write at t+1 to the same address returns the old data.
- Host worst-case wait under continuous v_req: MAX_WAIT cycles, then granted in the next cycle. VGA then loses exactly that one slot and is granted the following cycle.
- v_req and h_req high at the same time with h_wait < MAX_WAIT: VGA wins, and h_wait increments.

## Test plan
- Reset, then idle for 10 cycles → all outputs 0; ram_wren_b never 1.
- VGA read: preload addr 0x10 = 0xA5; v_req with v_addr = 0x10 in cycle t → v_gnt in t; ram_addr_b = 0x10 in t+1; v_rvalid with v_rdata = 0xA5 in t+3 only; h_rvalid stays 0.
- Host write then read: write 0x3C to 0x20, then read 0x20 → ram_wren_b high for exactly 1 cycle; h_rdata = 0x3C; exactly one h_rvalid pulse, none for the write.
- Starvation: v_req held high continuously and h_req raised at cycle 0 → h_gnt at cycle 15 with v_gnt low in that cycle; h_forced is 1 the cycle after; v_gnt returns at cycle 16.
- Interleaved reads: alternating VGA reads of 0x01 and host reads of 0x02 every cycle (forced by MAX_WAIT = 1) → each returned word goes to the correct owner, in grant order.
- Reset mid-flight: v_req granted at t, reset asserted at t+1 → no v_rvalid at t+3; all outputs 0 at t+2.
